// File: rtl/exc_commit_ctrl_pkg.sv
// Shared definitions for the exception commit controller:
// FSM state encoding, wb_ex_src bit positions and the default exception vector.
package exc_commit_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_FLUSH    = 2'd1,
    ST_REDIRECT = 2'd2
  } state_e;

  // Bit positions inside wb_ex_src. The lowest index has the highest priority.
  localparam int unsigned EX_ADEL = 0;
  localparam int unsigned EX_ADES = 1;
  localparam int unsigned EX_SYS  = 2;
  localparam int unsigned EX_BP   = 3;
  localparam int unsigned EX_RI   = 4;
  localparam int unsigned EX_OV   = 5;
  localparam int unsigned EX_W    = 6;

  localparam logic [31:0] EXC_VECTOR_DEFAULT = 32'hBFC0_0380;

endpackage

// File: rtl/exc_commit_ctrl_prio_enc.sv
// Lowest-index-first one-hot encoder for the raw exception flags.
module exc_prio_enc
  import exc_commit_ctrl_pkg::*;
(
  input  logic [EX_W-1:0] req_i,
  output logic [EX_W-1:0] onehot_o
);

  // Isolate the lowest set bit: x & -x, written as x & (~x + 1).
  assign onehot_o = req_i & (~req_i + EX_W'(1));

endmodule

// File: rtl/exc_commit_ctrl.sv
// Exception / ERET commit controller.
// An exception or ERET at commit strobes CP0, flushes the younger pipeline
// for FLUSH_CYCLES cycles, then holds a fetch redirect until accepted.
// Optional feature macro: INT_EN adds int_pending / ex_int, where a pending
// interrupt outranks every exception flag and ERET.
module exc_commit_ctrl
  import exc_commit_ctrl_pkg::*;
#(
  parameter logic [31:0] EXC_VECTOR   = EXC_VECTOR_DEFAULT,
  parameter int unsigned FLUSH_CYCLES = 2
) (
  input  logic        clock,
  input  logic        resetn,
  input  logic        wb_valid,
  input  logic [31:0] wb_pc,
  input  logic        wb_is_bd,
  input  logic [5:0]  wb_ex_src,
  input  logic        wb_eret,
  input  logic [31:0] cp0_epc,
`ifdef INT_EN
  input  logic        int_pending,
  output logic        ex_int,
`endif
  output logic [5:0]  ex,
  output logic [31:0] epc_in,
  output logic        is_bd,
  output logic        cp0_valid,
  output logic        inst_ERET,
  output logic        flush,
  output logic        commit_stall,
  output logic        redir_valid,
  output logic [31:0] redir_pc,
  input  logic        redir_ready
);

  localparam logic [3:0] FLUSH_LOAD = 4'(FLUSH_CYCLES);

  state_e      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [31:0] target_q, target_d;

  logic [5:0]  ex_onehot;
  logic        take;
  logic        int_evt;
  logic        exc_evt;
  logic        eret_evt;
  logic        any_evt;

  exc_prio_enc u_prio_enc (
    .req_i    (wb_ex_src),
    .onehot_o (ex_onehot)
  );

  // Gating with resetn keeps every combinational strobe at 0 while reset is held.
  assign take = (state_q == ST_IDLE) && resetn && wb_valid;

`ifdef INT_EN
  assign int_evt = take && int_pending;
`else
  assign int_evt = 1'b0;
`endif
  assign exc_evt  = take && (|wb_ex_src) && !int_evt;
  assign eret_evt = take && wb_eret && !(|wb_ex_src) && !int_evt;
  assign any_evt  = int_evt || exc_evt || eret_evt;

  // State, drain counter and redirect target registers.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state_q  <= ST_IDLE;
      cnt_q    <= '0;
      target_q <= '0;
    end else begin
      // NOTE: non-blocking assignments so every register samples pre-edge values.
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      target_q <= target_d;
    end
  end

  // Next-state logic: capture target on an event, count down the drain, await handshake.
  always_comb begin
    // NOTE: defaults first so no path leaves a variable unassigned (no latches).
    state_d  = state_q;
    cnt_d    = cnt_q;
    target_d = target_q;
    unique case (state_q)
      ST_IDLE: begin
        if (any_evt) begin
          state_d  = ST_FLUSH;
          cnt_d    = FLUSH_LOAD;
          target_d = eret_evt ? cp0_epc : EXC_VECTOR;
        end
      end
      ST_FLUSH: begin
        cnt_d = cnt_q - 4'd1;
        if (cnt_q <= 4'd1) begin
          state_d = ST_REDIRECT;
        end
      end
      ST_REDIRECT: begin
        if (redir_ready) begin
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // Output logic: event-cycle CP0 strobes plus state-derived flush/stall/redirect.
  always_comb begin
    ex           = exc_evt ? ex_onehot : '0;
    epc_in       = '0;
    is_bd        = 1'b0;
    cp0_valid    = any_evt;
    inst_ERET    = eret_evt;
    flush        = any_evt || (state_q == ST_FLUSH);
    commit_stall = (state_q != ST_IDLE);
    redir_valid  = (state_q == ST_REDIRECT);
    redir_pc     = (state_q == ST_REDIRECT) ? target_q : '0;
    if (any_evt) begin
      epc_in = wb_is_bd ? (wb_pc - 32'd4) : wb_pc;
      is_bd  = wb_is_bd;
    end
`ifdef INT_EN
    ex_int = int_evt;
`endif
  end

endmodule

// File: tb/tb_exc_commit_ctrl.sv
// Self-checking bench for exc_commit_ctrl: a table of single-event vectors,
// each drained through FLUSH and REDIRECT, plus hand-written multi-cycle sequences.
module tb_exc_commit_ctrl;

  localparam logic [31:0] EXC_VEC = 32'hBFC0_0380;
  localparam int          NFLUSH  = 2;

  logic        clock;
  logic        resetn;
  logic        wb_valid;
  logic [31:0] wb_pc;
  logic        wb_is_bd;
  logic [5:0]  wb_ex_src;
  logic        wb_eret;
  logic [31:0] cp0_epc;
  logic [5:0]  ex;
  logic [31:0] epc_in;
  logic        is_bd;
  logic        cp0_valid;
  logic        inst_ERET;
  logic        flush;
  logic        commit_stall;
  logic        redir_valid;
  logic [31:0] redir_pc;
  logic        redir_ready;
`ifdef INT_EN
  logic        int_pending;
  logic        ex_int;
`endif

  int pass_cnt = 0;
  int total_cnt = 0;

  exc_commit_ctrl #(
    .EXC_VECTOR   (EXC_VEC),
    .FLUSH_CYCLES (NFLUSH)
  ) dut (
    .clock        (clock),
    .resetn       (resetn),
    .wb_valid     (wb_valid),
    .wb_pc        (wb_pc),
    .wb_is_bd     (wb_is_bd),
    .wb_ex_src    (wb_ex_src),
    .wb_eret      (wb_eret),
    .cp0_epc      (cp0_epc),
`ifdef INT_EN
    .int_pending  (int_pending),
    .ex_int       (ex_int),
`endif
    .ex           (ex),
    .epc_in       (epc_in),
    .is_bd        (is_bd),
    .cp0_valid    (cp0_valid),
    .inst_ERET    (inst_ERET),
    .flush        (flush),
    .commit_stall (commit_stall),
    .redir_valid  (redir_valid),
    .redir_pc     (redir_pc),
    .redir_ready  (redir_ready)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct {
    logic        valid;
    logic [31:0] pc;
    logic        bd;
    logic [5:0]  src;
    logic        eret;
    logic [31:0] epc;
    logic [5:0]  exp_ex;
    logic [31:0] exp_epc_in;
    logic        exp_bd;
    logic        exp_cp0v;
    logic        exp_eret;
    logic [31:0] exp_target;
  } vec_t;

  vec_t vecs[8];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %h, expected %h", name, act, exp);
  endtask

  task automatic clear_wb();
    wb_valid  = 1'b0;
    wb_pc     = '0;
    wb_is_bd  = 1'b0;
    wb_ex_src = '0;
    wb_eret   = 1'b0;
    cp0_epc   = '0;
  endtask

  // Called the cycle after an accepted event: walks the drain and completes the redirect.
  task automatic drain(input string tag, input logic [31:0] exp_target);
    for (int i = 0; i < NFLUSH; i++) begin
      @(negedge clock);
      clear_wb();
      #1;
      check({tag, " flush"}, 32'(flush), 32'd1);
      check({tag, " stall"}, 32'(commit_stall), 32'd1);
      check({tag, " early_redir"}, 32'(redir_valid), 32'd0);
    end
    @(negedge clock);
    #1;
    check({tag, " redir_valid"}, 32'(redir_valid), 32'd1);
    check({tag, " redir_pc"}, redir_pc, exp_target);
    check({tag, " flush_off"}, 32'(flush), 32'd0);
    redir_ready = 1'b1;
    @(negedge clock);
    redir_ready = 1'b0;
    #1;
    check({tag, " idle_stall"}, 32'(commit_stall), 32'd0);
    check({tag, " idle_redir"}, 32'(redir_valid), 32'd0);
  endtask

  initial begin
    //                valid  pc             bd    src        eret  cp0_epc        ex         epc_in         bd    cp0v  eret  target
    vecs[0] = '{1'b1, 32'h8000_0010, 1'b0, 6'b010100, 1'b0, 32'h0,         6'b000100, 32'h8000_0010, 1'b0, 1'b1, 1'b0, EXC_VEC};
    vecs[1] = '{1'b1, 32'h0000_0000, 1'b1, 6'b000001, 1'b0, 32'h0,         6'b000001, 32'hFFFF_FFFC, 1'b1, 1'b1, 1'b0, EXC_VEC};
    vecs[2] = '{1'b1, 32'h8000_1000, 1'b0, 6'b000000, 1'b1, 32'h8000_0200, 6'b000000, 32'h8000_1000, 1'b0, 1'b1, 1'b1, 32'h8000_0200};
    vecs[3] = '{1'b1, 32'h0000_1234, 1'b0, 6'b100000, 1'b1, 32'h8000_0200, 6'b100000, 32'h0000_1234, 1'b0, 1'b1, 1'b0, EXC_VEC};
    vecs[4] = '{1'b0, 32'h8000_0040, 1'b1, 6'b111111, 1'b1, 32'h8000_0300, 6'b000000, 32'h0,         1'b0, 1'b0, 1'b0, 32'h0};
    vecs[5] = '{1'b1, 32'h0040_0008, 1'b1, 6'b110000, 1'b0, 32'h0,         6'b010000, 32'h0040_0004, 1'b1, 1'b1, 1'b0, EXC_VEC};
    vecs[6] = '{1'b1, 32'h8000_0080, 1'b1, 6'b000000, 1'b0, 32'h8000_0400, 6'b000000, 32'h0,         1'b0, 1'b0, 1'b0, 32'h0};
    vecs[7] = '{1'b1, 32'h8000_00A0, 1'b0, 6'b001010, 1'b1, 32'h8000_0500, 6'b000010, 32'h8000_00A0, 1'b0, 1'b1, 1'b0, EXC_VEC};

    resetn      = 1'b0;
    redir_ready = 1'b0;
    clear_wb();
`ifdef INT_EN
    int_pending = 1'b0;
`endif

    // Reset state: live event inputs must not leak through while reset is held.
    @(negedge clock);
    wb_valid  = 1'b1;
    wb_ex_src = 6'b000001;
    wb_eret   = 1'b1;
    wb_pc     = 32'h1111_1110;
    #1;
    check("rst cp0_valid", 32'(cp0_valid), 32'd0);
    check("rst ex", 32'(ex), 32'd0);
    check("rst flush", 32'(flush), 32'd0);
    check("rst stall", 32'(commit_stall), 32'd0);
    check("rst redir_valid", 32'(redir_valid), 32'd0);
    check("rst epc_in", epc_in, 32'd0);
    @(negedge clock);
    clear_wb();
    resetn = 1'b1;

    // Table of single-cycle events, each followed by a full drain when accepted.
    for (int i = 0; i < 8; i++) begin
      @(negedge clock);
      wb_valid  = vecs[i].valid;
      wb_pc     = vecs[i].pc;
      wb_is_bd  = vecs[i].bd;
      wb_ex_src = vecs[i].src;
      wb_eret   = vecs[i].eret;
      cp0_epc   = vecs[i].epc;
      #1;
      check($sformatf("v%0d ex", i), 32'(ex), 32'(vecs[i].exp_ex));
      check($sformatf("v%0d epc_in", i), epc_in, vecs[i].exp_epc_in);
      check($sformatf("v%0d is_bd", i), 32'(is_bd), 32'(vecs[i].exp_bd));
      check($sformatf("v%0d cp0_valid", i), 32'(cp0_valid), 32'(vecs[i].exp_cp0v));
      check($sformatf("v%0d inst_ERET", i), 32'(inst_ERET), 32'(vecs[i].exp_eret));
      check($sformatf("v%0d flush", i), 32'(flush), 32'(vecs[i].exp_cp0v));
      if (vecs[i].exp_cp0v) begin
        drain($sformatf("v%0d", i), vecs[i].exp_target);
      end else begin
        @(negedge clock);
        clear_wb();
        #1;
        check($sformatf("v%0d no_evt_stall", i), 32'(commit_stall), 32'd0);
      end
    end

    // ERET with a stalled redirect; stray redir_ready and wb_* outside IDLE are ignored.
    @(negedge clock);
    wb_valid = 1'b1;
    wb_eret  = 1'b1;
    wb_pc    = 32'h8000_0600;
    cp0_epc  = 32'h8000_0200;
    #1;
    check("eret_hold inst_ERET", 32'(inst_ERET), 32'd1);
    @(negedge clock);
    wb_eret     = 1'b0;
    wb_ex_src   = 6'b000100;
    cp0_epc     = 32'h1234_5678;
    redir_ready = 1'b1;
    #1;
    check("eret_hold flush1", 32'(flush), 32'd1);
    check("eret_hold ignore cp0_valid", 32'(cp0_valid), 32'd0);
    check("eret_hold ignore ex", 32'(ex), 32'd0);
    @(negedge clock);
    redir_ready = 1'b0;
    #1;
    check("eret_hold flush2", 32'(flush), 32'd1);
    for (int i = 0; i < 4; i++) begin
      @(negedge clock);
      #1;
      check($sformatf("eret_hold redir_valid c%0d", i), 32'(redir_valid), 32'd1);
      check($sformatf("eret_hold redir_pc c%0d", i), redir_pc, 32'h8000_0200);
      check($sformatf("eret_hold stall c%0d", i), 32'(commit_stall), 32'd1);
    end
    clear_wb();
    redir_ready = 1'b1;
    @(negedge clock);
    redir_ready = 1'b0;
    #1;
    check("eret_hold idle stall", 32'(commit_stall), 32'd0);
    check("eret_hold idle redir", 32'(redir_valid), 32'd0);

    // Reset pulsed mid-FLUSH, then an event on the first edge after release.
    @(negedge clock);
    wb_valid  = 1'b1;
    wb_ex_src = 6'b001000;
    wb_pc     = 32'h8000_0700;
    @(negedge clock);
    #1;
    check("rst_mid flush before", 32'(flush), 32'd1);
    resetn = 1'b0;
    #1;
    check("rst_mid flush", 32'(flush), 32'd0);
    check("rst_mid stall", 32'(commit_stall), 32'd0);
    check("rst_mid cp0_valid", 32'(cp0_valid), 32'd0);
    check("rst_mid redir_valid", 32'(redir_valid), 32'd0);
    check("rst_mid redir_pc", redir_pc, 32'd0);
    @(negedge clock);
    resetn    = 1'b1;
    wb_valid  = 1'b1;
    wb_ex_src = 6'b000010;
    wb_is_bd  = 1'b1;
    wb_pc     = 32'h8000_0804;
    #1;
    check("rst_after ex", 32'(ex), 32'd2);
    check("rst_after epc_in", epc_in, 32'h8000_0800);
    drain("rst_after", EXC_VEC);

`ifdef INT_EN
    // Pending interrupt outranks the exception flag.
    @(negedge clock);
    wb_valid    = 1'b1;
    wb_ex_src   = 6'b000100;
    wb_pc       = 32'h8000_0900;
    int_pending = 1'b1;
    #1;
    check("int ex_int", 32'(ex_int), 32'd1);
    check("int ex", 32'(ex), 32'd0);
    check("int cp0_valid", 32'(cp0_valid), 32'd1);
    check("int epc_in", epc_in, 32'h8000_0900);
    @(negedge clock);
    int_pending = 1'b0;
    #1;
    check("int ex_int drop", 32'(ex_int), 32'd0);
    for (int i = 0; i < NFLUSH - 1; i++) begin
      @(negedge clock);
      clear_wb();
    end
    @(negedge clock);
    #1;
    check("int redir_pc", redir_pc, EXC_VEC);
    redir_ready = 1'b1;
    @(negedge clock);
    redir_ready = 1'b0;
`endif

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
